// File: rtl/muldiv_pkg.sv
// Shared func codes, FSM state type and default width for the HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int MD_DATA_W = 32;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned shift-add multiplier / restoring divider on a 2*DATA_W accumulator.
// Latency: DATA_W cycles from start; done is high during the final iteration cycle.
// Backpressure: none; start is honoured on any cycle and restarts the datapath.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                is_div,
    input  logic [DATA_W-1:0]   opa,
    input  logic [DATA_W-1:0]   opb,
    output logic                done,
    output logic [2*DATA_W-1:0] acc
);

    logic [DATA_W-1:0] opb_q;
    logic [CNT_W-1:0]  cnt;
    logic              running;
    logic              div_mode;
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_trial;

    always_comb begin
        mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opb_q} : '0);
        // Remainder shifted left by one, compared against the divisor with a borrow bit.
        div_trial = acc[2*DATA_W-1:DATA_W-1] - {1'b0, opb_q};
        done      = running && (cnt == CNT_W'(DATA_W - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            opb_q    <= '0;
            cnt      <= '0;
            running  <= 1'b0;
            div_mode <= 1'b0;
        end else if (start) begin
            acc      <= {{DATA_W{1'b0}}, opa};
            opb_q    <= opb;
            cnt      <= '0;
            running  <= 1'b1;
            div_mode <= is_div;
        end else if (running) begin
            cnt <= cnt + 1'b1;
            if (done)
                running <= 1'b0;
            if (div_mode) begin
                if (!div_trial[DATA_W])
                    acc <= {div_trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
                else
                    acc <= {acc[2*DATA_W-2:0], 1'b0};
            end else begin
                acc <= {mul_sum, acc[DATA_W-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: decode, HI/LO state, sign fixing and stall (MULDIV_FAST_MUL_EN: 1-cycle multiply).
// Latency: iterative ops write HI/LO DATA_W+1 edges after issue; mf is combinational, mt writes at issue.
// Backpressure: stall asserts while busy for any muldiv/mf/mt request; the core reissues it.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [5:0]        op,
    input  logic [5:0]        func,
    input  logic [DATA_W-1:0] busA,
    input  logic [DATA_W-1:0] busB,
    output logic              busy,
    output logic              stall,
    output logic [DATA_W-1:0] hilo_out
);

    muldiv_state_t       state;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
    logic                neg_q;
    logic                neg_r;
    logic                div_q;
    logic                div0_q;
    logic [DATA_W-1:0]   a_raw;

    logic                sel;
    logic                is_mul;
    logic                is_divop;
    logic                is_signed;
    logic                md_start;
    logic                mf;
    logic                mt;
    logic                core_start;
    logic                core_done;
    logic [DATA_W-1:0]   abs_a;
    logic [DATA_W-1:0]   abs_b;
    logic [2*DATA_W-1:0] core_acc;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   fix_hi;
    logic [DATA_W-1:0]   fix_lo;
`ifdef MULDIV_FAST_MUL_EN
    logic                fast_mul;
    logic [2*DATA_W-1:0] mul_a;
    logic [2*DATA_W-1:0] mul_b;
    logic [2*DATA_W-1:0] mul_p;
`endif

    always_comb begin
        sel       = en && (op == 6'b000000);
        is_mul    = (func == FN_MULT) || (func == FN_MULTU);
        is_divop  = (func == FN_DIV)  || (func == FN_DIVU);
        is_signed = (func == FN_MULT) || (func == FN_DIV);
        md_start  = sel && (is_mul || is_divop);
        mf        = sel && ((func == FN_MFHI) || (func == FN_MFLO));
        mt        = sel && ((func == FN_MTHI) || (func == FN_MTLO));
        abs_a     = (is_signed && busA[DATA_W-1]) ? -busA : busA;
        abs_b     = (is_signed && busB[DATA_W-1]) ? -busB : busB;
`ifdef MULDIV_FAST_MUL_EN
        fast_mul   = md_start && is_mul;
        core_start = (state == IDLE) && md_start && !is_mul;
        mul_a      = {{DATA_W{is_signed & busA[DATA_W-1]}}, busA};
        mul_b      = {{DATA_W{is_signed & busB[DATA_W-1]}}, busB};
        mul_p      = mul_a * mul_b;
`else
        core_start = (state == IDLE) && md_start;
`endif
        busy     = (state != IDLE);
        stall    = busy && (md_start || mf || mt);
        hilo_out = mf ? ((func == FN_MFHI) ? hi : lo) : '0;

        prod_fix = neg_q ? -core_acc : core_acc;
        if (!div_q) begin
            fix_hi = prod_fix[2*DATA_W-1:DATA_W];
            fix_lo = prod_fix[DATA_W-1:0];
        end else if (div0_q) begin
            // Divide by zero reports the untouched dividend, regardless of signedness.
            fix_hi = a_raw;
            fix_lo = '1;
        end else begin
            fix_hi = neg_r ? -core_acc[2*DATA_W-1:DATA_W] : core_acc[2*DATA_W-1:DATA_W];
            fix_lo = neg_q ? -core_acc[DATA_W-1:0] : core_acc[DATA_W-1:0];
        end
    end

    muldiv_core #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (core_start),
        .is_div (is_divop),
        .opa    (abs_a),
        .opb    (abs_b),
        .done   (core_done),
        .acc    (core_acc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            hi     <= '0;
            lo     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div_q  <= 1'b0;
            div0_q <= 1'b0;
            a_raw  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (core_start) begin
                        state  <= RUN;
                        neg_q  <= is_signed && (busA[DATA_W-1] ^ busB[DATA_W-1]);
                        neg_r  <= is_signed && busA[DATA_W-1];
                        div_q  <= is_divop;
                        div0_q <= (busB == '0);
                        a_raw  <= busA;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (fast_mul) begin
                        hi <= mul_p[2*DATA_W-1:DATA_W];
                        lo <= mul_p[DATA_W-1:0];
`endif
                    end else if (mt) begin
                        if (func == FN_MTHI)
                            hi <= busA;
                        else
                            lo <= busA;
                    end
                end
                RUN: begin
                    if (core_done)
                        state <= FIX;
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
